sprite_palette_bank: RTL and testbench

Programmable, multi-bank colour palette for the sprite/background pixel path. It replaces fixed per-sheet palette ROMs with a writable palette RAM holding `NUM_BANKS` banks of `2**INDEX_W` entries. Bank selection is frame-synchronous, and it adds a frame-stepped fade engine and a hit-flash effect. It sits between the sprite ROM index output and the VGA colour mux, with a 2-cycle registered lookup.

---
 rtl/sprite_palette_bank.sv | 137 +++++++++++++
 tb/tb_sprite_palette_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_bank.sv
// Multi-bank writable sprite palette with a 2-cycle registered lookup,
// frame-stepped fade engine and a frame-alternating hit flash.
module sprite_palette_bank #(
    parameter int INDEX_W         = 4,
    parameter int NUM_BANKS       = 4,
    parameter int COLOR_W         = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter int FADE_FRAMES     = 2,
    parameter int FLASH_FRAMES    = 16,
    localparam int BANK_W         = $clog2(NUM_BANKS)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   pix_valid,
    input  logic [INDEX_W-1:0]     pix_index,
    input  logic                   frame_start,
    input  logic [BANK_W-1:0]      bank_sel,
    input  logic                   wr_en,
    input  logic [BANK_W-1:0]      wr_bank,
    input  logic [INDEX_W-1:0]     wr_index,
    input  logic [3*COLOR_W-1:0]   wr_rgb,
    input  logic [1:0]             fade_cmd,
    input  logic                   flash_req,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   rgb_valid,
    output logic                   transparent,
    output logic                   fade_busy
);
    localparam int RGB_W  = 3 * COLOR_W;
    localparam int DEPTH  = NUM_BANKS << INDEX_W;
    localparam int STAGES = 2;
    localparam int SW     = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam int FW     = $clog2(FLASH_FRAMES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OUT  = 2'd1;
    localparam logic [1:0] S_IN   = 2'd2;

    logic [RGB_W-1:0]  mem [DEPTH];
    logic [BANK_W-1:0] active_bank;
    logic [RGB_W-1:0]  s1_rgb;
    logic              s1_trans;
    logic [STAGES:1]   vld_pipe;
    logic [1:0]        state;
    logic [3:0]        level;
    logic [SW-1:0]     step;
    logic [FW-1:0]     flash_cnt;
    logic              flash_force;

    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [3:0] lv);
        logic [COLOR_W+3:0] p;
        p = (COLOR_W+4)'(c) * (COLOR_W+4)'({1'b0, lv} + 5'd1);
        return p[COLOR_W+3:4];
    endfunction

    // Palette contents deliberately survive Reset.
    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[{wr_bank, wr_index}] <= wr_rgb;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            active_bank <= '0;
        else if (frame_start)
            active_bank <= bank_sel;
    end

    assign flash_force = (flash_cnt != '0) && flash_cnt[0] && !s1_trans;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_rgb      <= '0;
            s1_trans    <= 1'b0;
            vld_pipe    <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else begin
            s1_rgb      <= mem[{active_bank, pix_index}];
            s1_trans    <= (pix_index == INDEX_W'(TRANSPARENT_IDX));
            vld_pipe    <= {vld_pipe[STAGES-1:1], pix_valid};
            red         <= flash_force ? '1 : scale(s1_rgb[RGB_W-1 -: COLOR_W], level);
            green       <= flash_force ? '1 : scale(s1_rgb[2*COLOR_W-1 -: COLOR_W], level);
            blue        <= flash_force ? '1 : scale(s1_rgb[COLOR_W-1:0], level);
            transparent <= s1_trans;
        end
    end

    assign rgb_valid = vld_pipe[STAGES];
    assign fade_busy = (state != S_IDLE);

    // Commands override frame steps; level saturates and the FSM idles at the end stop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            level <= 4'hF;
            step  <= '0;
        end else if (fade_cmd == 2'b11) begin
            state <= S_IDLE;
            level <= 4'hF;
            step  <= '0;
        end else if (fade_cmd == 2'b01) begin
            state <= S_OUT;
            step  <= '0;
        end else if (fade_cmd == 2'b10) begin
            state <= S_IN;
            step  <= '0;
        end else if (frame_start && state != S_IDLE) begin
            if (step == SW'(FADE_FRAMES - 1)) begin
                step <= '0;
                if (state == S_OUT) begin
                    if (level != 4'h0) level <= level - 4'd1;
                    if (level <= 4'h1) state <= S_IDLE;
                end else begin
                    if (level != 4'hF) level <= level + 4'd1;
                    if (level >= 4'hE) state <= S_IDLE;
                end
            end else begin
                step <= step + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            flash_cnt <= '0;
        else if (flash_req)
            flash_cnt <= FW'(FLASH_FRAMES);
        else if (frame_start && flash_cnt != '0)
            flash_cnt <= flash_cnt - 1'b1;
    end
endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank; lookups push expectations to a
// scoreboard that a negedge monitor pops as rgb_valid pixels emerge.
module tb_sprite_palette_bank;
    logic        Clk = 1'b0, Reset = 1'b1;
    logic        pix_valid = 1'b0, frame_start = 1'b0, wr_en = 1'b0, flash_req = 1'b0;
    logic [3:0]  pix_index = '0, wr_index = '0;
    logic [1:0]  bank_sel = '0, wr_bank = '0, fade_cmd = '0;
    logic [11:0] wr_rgb = '0;
    logic [3:0]  red, green, blue;
    logic        rgb_valid, transparent, fade_busy;

    typedef struct {
        logic [11:0] rgb;
        logic        tr;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ncmp = 0, nerr = 0;

    sprite_palette_bank dut (
        .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .pix_index(pix_index),
        .frame_start(frame_start), .bank_sel(bank_sel), .wr_en(wr_en),
        .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
        .fade_cmd(fade_cmd), .flash_req(flash_req), .red(red), .green(green),
        .blue(blue), .rgb_valid(rgb_valid), .transparent(transparent),
        .fade_busy(fade_busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] fade(input logic [11:0] c, input int lv);
        logic [11:0] r;
        for (int k = 0; k < 3; k++)
            r[k*4 +: 4] = 4'((int'(c[k*4 +: 4]) * (lv + 1)) / 16);
        return r;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] i, input logic [11:0] d);
        wr_en = 1'b1; wr_bank = b; wr_index = i; wr_rgb = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic lookup(input logic [3:0] i, input logic [11:0] e, input logic tr);
        pix_valid = 1'b1; pix_index = i;
        q.push_back('{e, tr, cyc + 2});
        step();
        pix_valid = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (rgb_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_pixel", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", cyc, e.due);
                chk("rgb", {red, green, blue}, e.rgb);
                chk("transparent", transparent, e.tr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        repeat (3) step();
        chk("rst_rgb", {red, green, blue}, 12'h000);
        chk("rst_valid", rgb_valid, 1'b0);
        chk("rst_trans", transparent, 1'b0);
        chk("rst_busy", fade_busy, 1'b0);
        Reset = 1'b0;
        step();

        // bank select is frame-synchronous
        wr(2'd0, 4'd5, 12'h123);
        wr(2'd1, 4'd5, 12'hFB7);
        bank_sel = 2'd1;
        lookup(4'd5, 12'h123, 1'b0);
        frame_start = 1'b1;
        lookup(4'd5, 12'h123, 1'b0);
        frame_start = 1'b0;
        lookup(4'd5, 12'hFB7, 1'b0);
        repeat (3) step();

        // read-before-write collision
        wr(2'd1, 4'd3, 12'h148);
        wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd3; wr_rgb = 12'h0AF;
        lookup(4'd3, 12'h148, 1'b0);
        wr_en = 1'b0;
        lookup(4'd3, 12'h0AF, 1'b0);
        repeat (3) step();

        // fade out; command with frame_start takes no step
        wr(2'd1, 4'd7, 12'hFFF);
        fade_cmd = 2'b01; frame_start = 1'b1;
        step();
        fade_cmd = 2'b00; frame_start = 1'b0;
        chk("busy_fade_out", fade_busy, 1'b1);
        frames(1);
        lookup(4'd7, 12'hFFF, 1'b0);
        frames(1);
        lookup(4'd7, 12'hEEE, 1'b0);
        frames(28);
        chk("busy_after_out", fade_busy, 1'b0);
        lookup(4'd7, 12'h000, 1'b0);
        frames(4);
        lookup(4'd7, 12'h000, 1'b0);
        fade_cmd = 2'b11; step(); fade_cmd = 2'b00;
        lookup(4'd7, 12'hFFF, 1'b0);
        repeat (3) step();

        // fade out to 8, redirect in without a jump
        fade_cmd = 2'b01; step(); fade_cmd = 2'b00;
        frames(14);
        lookup(4'd7, fade(12'hFFF, 8), 1'b0);
        fade_cmd = 2'b10; step(); fade_cmd = 2'b00;
        lookup(4'd7, fade(12'hFFF, 8), 1'b0);
        for (int lv = 9; lv <= 15; lv++) begin
            frames(2);
            lookup(4'd7, fade(12'hFFF, lv), 1'b0);
            if (lv == 14) chk("busy_mid_in", fade_busy, 1'b1);
        end
        chk("busy_after_in", fade_busy, 1'b0);

        // fade in at level 15 enters, then idles on first step
        fade_cmd = 2'b10; step(); fade_cmd = 2'b00;
        chk("busy_in_at15", fade_busy, 1'b1);
        frames(2);
        chk("idle_in_at15", fade_busy, 1'b0);
        lookup(4'd7, 12'hFFF, 1'b0);
        repeat (3) step();

        // hit flash; req with frame_start loads without decrement
        wr(2'd1, 4'd2, 12'h101);
        wr(2'd1, 4'd0, 12'h3C9);
        flash_req = 1'b1; frame_start = 1'b1;
        step();
        flash_req = 1'b0; frame_start = 1'b0;
        fc = 16;
        for (int f = 0; f < 17; f++) begin
            lookup(4'd2, fc[0] ? 12'hFFF : 12'h101, 1'b0);
            lookup(4'd0, 12'h3C9, 1'b1);
            frames(1);
            if (fc != 0) fc--;
        end
        repeat (3) step();

        // reset mid-fade with continuous pixels
        fade_cmd = 2'b01; step(); fade_cmd = 2'b00;
        frames(4);
        lookup(4'd7, fade(12'hFFF, 13), 1'b0);
        repeat (3) step();
        pix_valid = 1'b1; pix_index = 4'd7;
        repeat (3) begin
            q.push_back('{fade(12'hFFF, 13), 1'b0, cyc + 2});
            step();
        end
        Reset = 1'b1;
        while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        step();
        chk("mid_rst_rgb", {red, green, blue}, 12'h000);
        chk("mid_rst_valid", rgb_valid, 1'b0);
        chk("mid_rst_busy", fade_busy, 1'b0);
        pix_valid = 1'b0;
        step();
        Reset = 1'b0;
        lookup(4'd5, 12'h123, 1'b0);
        frames(1);
        lookup(4'd7, 12'hFFF, 1'b0);
        repeat (4) step();
        chk("sb_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
